// File: rtl/prog_clock_divider.sv
// prog_clock_divider: NUM_CH runtime-programmable clock-enable generators whose new settings
// take effect only at a period boundary. Define CLKDIV_SYNC_EN to add the sync phase-restart input.
module prog_clock_divider #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 32,
  parameter int DEFAULT_PERIOD = 150_000_000,
  parameter int DEFAULT_HIGH   = DEFAULT_PERIOD / 2,
  parameter int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_period,
  input  logic [CNT_W-1:0]  wr_high,
  input  logic [NUM_CH-1:0] ch_en,
`ifdef CLKDIV_SYNC_EN
  input  logic              sync,
`endif
  output logic [NUM_CH-1:0] clk_slow,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);

  function automatic logic [CNT_W-1:0] clamp_period(input logic [CNT_W-1:0] p);
    return (p < CNT_W'(2)) ? CNT_W'(2) : p;
  endfunction

  // High time is clamped against the already-clamped period so clk_slow always has a low phase.
  function automatic logic [CNT_W-1:0] clamp_high(input logic [CNT_W-1:0] p,
                                                  input logic [CNT_W-1:0] h);
    logic [CNT_W-1:0] x;
    x = (h == '0) ? CNT_W'(1) : h;
    if (x >= p) x = p - CNT_W'(1);
    return x;
  endfunction

  localparam logic [CNT_W-1:0] DEF_PERIOD = clamp_period(CNT_W'(DEFAULT_PERIOD));
  localparam logic [CNT_W-1:0] DEF_HIGH   = clamp_high(DEF_PERIOD, CNT_W'(DEFAULT_HIGH));

  logic [CNT_W-1:0] wr_period_c;
  logic [CNT_W-1:0] wr_high_c;
  logic             sync_now;

  always_comb begin
    wr_period_c = clamp_period(wr_period);
    wr_high_c   = clamp_high(wr_period_c, wr_high);
  end

`ifdef CLKDIV_SYNC_EN
  assign sync_now = sync;
`else
  assign sync_now = 1'b0;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] active_period;
    logic [CNT_W-1:0] active_high;
    logic [CNT_W-1:0] shadow_period;
    logic [CNT_W-1:0] shadow_high;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] high_nxt;
    logic             pend;
    logic             run;
    logic             wr_hit;
    logic             at_end;
    logic             restart;
    logic             apply;
    logic             slow_p1;
    logic             tick_p1;

    // run remembers the previous ch_en so the first enabled cycle restarts at cnt=0.
    always_comb begin
      wr_hit   = wr_en && (wr_ch == CH_W'(g));
      at_end   = (cnt == active_period - CNT_W'(1));
      restart  = sync_now || !run || at_end;
      apply    = pend && (!ch_en[g] || sync_now || (run && at_end));
      cnt_nxt  = '0;
      if (ch_en[g] && !restart) cnt_nxt = cnt + CNT_W'(1);
      high_nxt = apply ? shadow_high : active_high;
    end

    // Outputs register the waveform for cnt_nxt so they line up with the counter state.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        active_period <= DEF_PERIOD;
        active_high   <= DEF_HIGH;
        shadow_period <= DEF_PERIOD;
        shadow_high   <= DEF_HIGH;
        cnt           <= '0;
        run           <= 1'b0;
        pend          <= 1'b0;
        slow_p1       <= 1'b0;
        tick_p1       <= 1'b0;
      end else begin
        run     <= ch_en[g];
        cnt     <= cnt_nxt;
        slow_p1 <= ch_en[g] && (cnt_nxt < high_nxt);
        tick_p1 <= ch_en[g] && (cnt_nxt == '0);
        if (apply) begin
          active_period <= shadow_period;
          active_high   <= shadow_high;
          pend          <= 1'b0;
        end
        // A write coinciding with an apply lands after the copy and stays pending.
        if (wr_hit) begin
          shadow_period <= wr_period_c;
          shadow_high   <= wr_high_c;
          pend          <= 1'b1;
        end
      end
    end

    assign clk_slow[g] = slow_p1;
    assign tick[g]     = tick_p1;
    assign pending[g]  = pend;
  end

endmodule
